pipeline_hazard_ctrl: RTL

- Central hazard controller for the 5-stage core (fetch, decode, execute, memory access, writeback).
- Keeps a two-slot scoreboard of in-flight destination registers (EX and MEM stages).
- Each cycle it produces the operand-forwarding selects, load-use stalls and branch-redirect flushes for the instruction currently in decode.
- Replaces the ad-hoc stall/forward generation inside decode; drives the fetch->decode and decode->execute flop enables directly.

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/pipeline_hazard_ctrl_if.sv | 37 +++
 rtl/pipeline_hazard_ctrl_scoreboard.sv | 28 ++
 rtl/pipeline_hazard_ctrl.sv | 92 +++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the core's hazard control: forwarding sources, pipeline stages,
// hazard FSM states and the scoreboard entry layout.
package cpu_pkg;

    // Width of register indices held in the scoreboard; must match REGISTER_SIZE.
    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        DECODE_RF_OPERAND      = 2'd0,
        MEM_ACCESS_DM_OPERAND  = 2'd1,
        EXECUTE_ALU_OPERAND    = 2'd2,
        MEM_ACCESS_ALU_OPERAND = 2'd3
    } fwd_src_e;

    typedef enum logic [2:0] {
        STAGE_FETCH,
        STAGE_DECODE,
        STAGE_EXECUTE,
        STAGE_MEM_ACCESS,
        STAGE_WRITEBACK
    } pipe_stage_e;

    typedef enum logic [1:0] {
        RUN,
        STALL,
        FLUSH
    } hazard_state_e;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             we;
        logic             is_load;
    } scoreboard_entry_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode-side hazard interface: decode instruction fields in, pipeline control and
// forwarding selects out.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned REGISTER_SIZE = 5,
    parameter int unsigned CNT_WIDTH     = 32
);
    logic                     id_valid;
    logic [REGISTER_SIZE-1:0] id_rs1;
    logic [REGISTER_SIZE-1:0] id_rs2;
    logic                     id_rs1_used;
    logic                     id_rs2_used;
    logic [REGISTER_SIZE-1:0] id_rd;
    logic                     id_rf_we;
    logic                     id_is_load;
    logic                     id_redirect;
    logic                     f_to_d_enable;
    logic                     d_to_e_enable;
    logic [1:0]               fwd_sel_a;
    logic [1:0]               fwd_sel_b;
    logic                     flush_decode;
    logic [CNT_WIDTH-1:0]     stall_count;
    logic [CNT_WIDTH-1:0]     flush_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rf_we,
               id_is_load, id_redirect,
        input  f_to_d_enable, d_to_e_enable, fwd_sel_a, fwd_sel_b, flush_decode,
               stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rf_we,
               id_is_load, id_redirect,
        output f_to_d_enable, d_to_e_enable, fwd_sel_a, fwd_sel_b, flush_decode,
               stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// Two-slot in-flight destination tracker (EX, MEM); a bubble enters EX when
// insert_bubble is set.
module hazard_scoreboard
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  scoreboard_entry_t ex_in,
    input  logic              insert_bubble,
    output scoreboard_entry_t ex_slot,
    output scoreboard_entry_t mem_slot
);
    scoreboard_entry_t ex_q, mem_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
        end else begin
            mem_q       <= ex_q;
            ex_q        <= ex_in;
            ex_q.valid  <= ex_in.valid & ~insert_bubble;
        end
    end

    assign ex_slot  = ex_q;
    assign mem_slot = mem_q;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage core: forwarding selects, load-use stalls and
// redirect flushes for the instruction in decode, plus stall/flush counters.
module pipeline_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned REGISTER_SIZE = 5,
    parameter int unsigned CNT_WIDTH     = 32
) (
    input logic                 clk,
    input logic                 rst,
    pipeline_hazard_ctrl_if.slave hz
);
    hazard_state_e        state_q, state_d;
    scoreboard_entry_t    ex_slot, mem_slot, ex_in;
    logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;
    logic                 dec_valid, rs1_act, rs2_act;
    logic                 ex_hit1, ex_hit2, mem_hit1, mem_hit2;
    logic                 load_use, stall, flush;

    function automatic fwd_src_e pick_src(logic act, logic ex_hit, logic ex_ld,
                                          logic mem_hit, logic mem_ld);
        if (!act)                 return DECODE_RF_OPERAND;
        else if (ex_hit && !ex_ld) return EXECUTE_ALU_OPERAND;
        else if (mem_hit)         return mem_ld ? MEM_ACCESS_DM_OPERAND : MEM_ACCESS_ALU_OPERAND;
        else                      return DECODE_RF_OPERAND;
    endfunction

    // The slot after a flush is a killed fetch, not a real instruction.
    assign dec_valid = hz.id_valid & (state_q != FLUSH);
    assign rs1_act   = hz.id_rs1_used & (hz.id_rs1 != '0);
    assign rs2_act   = hz.id_rs2_used & (hz.id_rs2 != '0);

    assign ex_hit1  = ex_slot.valid & ex_slot.we & (ex_slot.rd == REGISTER_SIZE'(hz.id_rs1));
    assign ex_hit2  = ex_slot.valid & ex_slot.we & (ex_slot.rd == REGISTER_SIZE'(hz.id_rs2));
    assign mem_hit1 = mem_slot.valid & mem_slot.we & (mem_slot.rd == REGISTER_SIZE'(hz.id_rs1));
    assign mem_hit2 = mem_slot.valid & mem_slot.we & (mem_slot.rd == REGISTER_SIZE'(hz.id_rs2));

    assign load_use = dec_valid & ex_slot.is_load & ((ex_hit1 & rs1_act) | (ex_hit2 & rs2_act));
    assign stall    = load_use;
    // A stall wins over a same-cycle redirect; decode presents it again next cycle.
    assign flush    = dec_valid & hz.id_redirect & ~load_use;

    assign ex_in = '{valid: hz.id_valid, rd: hz.id_rd, we: hz.id_rf_we, is_load: hz.id_is_load};

    hazard_scoreboard u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .ex_in         (ex_in),
        .insert_bubble (stall | (state_q == FLUSH)),
        .ex_slot       (ex_slot),
        .mem_slot      (mem_slot)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    // After a stall the load sits in MEM, so only a redirect can change the flow.
    always_comb begin
        state_d = RUN;
        unique case (state_q)
            RUN, STALL: begin
                if (load_use)   state_d = STALL;
                else if (flush) state_d = FLUSH;
            end
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        hz.f_to_d_enable = ~stall;
        hz.d_to_e_enable = ~stall;
        hz.flush_decode  = flush;
        hz.fwd_sel_a     = pick_src(rs1_act, ex_hit1, ex_slot.is_load, mem_hit1, mem_slot.is_load);
        hz.fwd_sel_b     = pick_src(rs2_act, ex_hit2, ex_slot.is_load, mem_hit2, mem_slot.is_load);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall) stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
            if (flush) flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign hz.stall_count = stall_cnt_q;
    assign hz.flush_count = flush_cnt_q;
endmodule
